// File: rtl/multibyte_add_sequencer.sv
// Multi-byte adder front end: feeds an 8-bit ripple-carry adder one byte per clock,
// LSB first, chaining the carry through a register and collecting sum, carry and flags.

module ripple_carry_adder (
    input  logic [7:0] ina,
    input  logic [7:0] inb,
    input  logic       inc,
    output logic [7:0] out,
    output logic       outc
);
    logic [8:0] c;

    always_comb begin
        c    = '0;
        out  = '0;
        c[0] = inc;
        for (int i = 0; i < 8; i++) begin
            out[i]   = ina[i] ^ inb[i] ^ c[i];
            c[i + 1] = (ina[i] & inb[i]) | (c[i] & (ina[i] ^ inb[i]));
        end
        outc = c[8];
    end
endmodule

module multibyte_add_sequencer #(
    parameter int WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [8*WORDS-1:0]   result,
    output logic                 carry_out,
    output logic                 zero,
    output logic                 overflow
);
    localparam int W = 8 * WORDS;
    localparam logic [1:0] IDX_LAST = 2'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           chain;
    logic [1:0]     idx;
    logic [4:0]     sel;
    logic [7:0]     a_byte;
    logic [7:0]     b_byte;
    logic [7:0]     sum;
    logic           sum_c;
    logic [W-1:0]   next_result;
    logic           accept;

    assign sel    = {idx, 3'b000};
    assign a_byte = a_reg[sel +: 8];
    assign b_byte = b_reg[sel +: 8];
    assign accept = start && (state == IDLE || state == DONE);

    ripple_carry_adder u_adder (a_byte, b_byte, chain, sum, sum_c);

    // Result as it will look once the current byte lands; zero flag needs the incoming byte.
    always_comb begin
        next_result            = result;
        next_result[sel +: 8]  = sum;
    end

    // Operand capture is pure data and carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= op_a;
            b_reg <= op_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            chain     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        chain <= carry_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    result <= next_result;
                    chain  <= sum_c;
                    idx    <= idx + 2'd1;
                    if (idx == IDX_LAST) begin
                        carry_out <= sum_c;
                        zero      <= (next_result == '0);
                        overflow  <= (a_reg[W-1] == b_reg[W-1]) && (sum[7] != a_reg[W-1]);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer: directed cases plus randomized
// operands compared against an arithmetic reference model.

module tb_multibyte_add_sequencer;
    localparam int WORDS = 2;
    localparam int W     = 8 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         overflow;

    int tests;
    int fails;

    multibyte_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] r, output logic co, output logic z, output logic ov);
        longint full;
        longint sa;
        longint sb;
        longint ss;
        full = longint'(a) + longint'(b) + longint'(c);
        r    = W'(full);
        co   = (full >= (64'sd1 <<< W));
        z    = (r == '0);
        sa   = a[W-1] ? longint'(a) - (64'sd1 <<< W) : longint'(a);
        sb   = b[W-1] ? longint'(b) - (64'sd1 <<< W) : longint'(b);
        ss   = sa + sb + longint'(c);
        ov   = (ss > ((64'sd1 <<< (W-1)) - 1)) || (ss < -(64'sd1 <<< (W-1)));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        int lat;
        logic [W-1:0] er;
        logic eco, ez, eov;
        model(a, b, c, er, eco, ez, eov);
        @(negedge clk);
        op_a = a; op_b = b; carry_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WORDS));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_carry"}, 32'(carry_out), 32'(eco));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        check({tag, "_ovf"}, 32'(overflow), 32'(eov));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int pulses;
        tests = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {29'd0, carry_out, zero, overflow}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_op("t1", 16'h00FF, 16'h0001, 1'b0);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0);
        run_op("t3a", 16'h7FFF, 16'h0001, 1'b0);
        run_op("t3b", 16'h8000, 16'h8000, 1'b0);

        // Second start while adding must be ignored.
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h4321; carry_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        op_a = 16'hFFFF; op_b = 16'hFFFF; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                check("t4_result", 32'(result), 32'h5556);
                check("t4_carry", 32'(carry_out), 32'd0);
            end
        end
        check("t4_pulses", 32'(pulses), 32'd1);

        // Back-to-back with start held high.
        @(negedge clk);
        op_a = 16'h0102; op_b = 16'h0304; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_e1_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("t5_first_done", 32'(done), 32'd1);
        check("t5_first_result", 32'(result), 32'h0406);
        op_a = 16'hFFFF; op_b = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_accept_done", 32'(done), 32'd0);
        check("t5_accept_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t5_mid_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("t5_second_done", 32'(done), 32'd1);
        check("t5_second_result", 32'(result), 32'hFFFE);
        check("t5_second_carry", 32'(carry_out), 32'd1);

        // Asynchronous reset in the middle of an addition.
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("t6_quiet", 32'(pulses), 32'd0);
        run_op("t6_fresh", 16'h1111, 16'h2222, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_op($sformatf("rnd%0d", n), W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
